instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage that sits directly downstream of the program counter register.
//  - Takes the current pc_val and issues a word read to instruction memory over a req/ack handshake.
//  - Presents the returned instruction to decode with a valid/ready handshake.
//  - Holds the PC via pc_stall (wired to the PC's Disable) until decode accepts the instruction.
//  - Discards in-flight fetches on flush (taken branch/jump).
// PARAMETERS
//  RESET_INSTR     32'h0000_0013  instruction driven on instr at reset and on timeout (RV32I NOP)
//  TIMEOUT_CYCLES  255            cycles in FETCH/DROP without mem_ack before abort (IFETCH_TIMEOUT_EN only)
//  CNT_W           8              width of timeout counter; TIMEOUT_CYCLES < 2**CNT_W
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  clr          in   1   reset, asynchronous, active-high
//  pc_val       in   32  current PC from the PC register
//  flush        in   1   discard current fetch/instruction (control-flow change)
//  instr_ready  in   1   decode accepts instr this cycle
//  instr        out  32  fetched instruction
//  instr_pc     out  32  address instr was fetched from
//  instr_valid  out  1   instr/instr_pc valid
//  pc_stall     out  1   hold PC; low exactly on the accept cycle
//  mem_read     out  1   memory read request, held until mem_ack
//  mem_addr     out  32  word-aligned read address
//  mem_rdata    in   32  read data, sampled when mem_ack=1
//  mem_ack      in   1   read complete
//  fetch_err    out  1   instruction is a timeout substitute (0 when feature off)
// BEHAVIOUR
//  Reset (clr=1, async):
//   - state=IDLE, addr_q=0, instr=RESET_INSTR, instr_pc=0.
//   - instr_valid=0, mem_read=0, fetch_err=0, counter=0.
//   - pc_stall=1 (combinational, see below).
//  States: IDLE, FETCH, VALID, DROP.
//  IDLE:
//   - Latch addr_q<=pc_val, go FETCH next cycle.
//   - flush has no effect.
//  FETCH:
//   - mem_read=1, mem_addr={addr_q[31:2],2'b00}. Low two bits are forced to 0, no fault.
//   - mem_ack=1, flush=0: instr<=mem_rdata, instr_pc<=addr_q, go VALID.
//   - mem_ack=1, flush=1: discard data, go IDLE.
//   - mem_ack=0, flush=1: go DROP.
//  DROP:
//   - mem_read stays 1 with the same mem_addr.
//   - On mem_ack, data is discarded and the block goes IDLE.
//   - flush is ignored.
//  VALID:
//   - instr_valid=1; instr and instr_pc are stable.
//   - flush=1: go IDLE without handshake. flush has priority over instr_ready.
//   - instr_ready=1, flush=0: handshake, go IDLE.
//  pc_stall = ~(state==VALID & instr_ready & ~flush).
//  mem_read is 0 in IDLE and VALID. mem_addr holds the last value outside FETCH/DROP.
//  Latency:
//   - Ack in the first FETCH cycle: IDLE(n) -> FETCH(n+1) -> instr_valid(n+2).
//   - Min throughput: 3 cycles/instr.
//   - PC advances on the accept cycle; IDLE then latches the new pc_val.
//  clr mid-fetch aborts immediately. A memory ack arriving after reset release in IDLE is ignored.
// CONFIGURATION
//  Macro IFETCH_TIMEOUT_EN:
//   Defined:
//   - Counter clears on entry to FETCH/DROP.
//   - Counter increments each cycle in FETCH/DROP with mem_ack=0.
//   - Reaching TIMEOUT_CYCLES in FETCH: drop mem_read, instr<=RESET_INSTR, instr_pc<=addr_q, fetch_err<=1, go VALID.
//   - Reaching TIMEOUT_CYCLES in DROP: go IDLE.
//   - fetch_err clears on handshake or flush out of VALID.
//   Undefined:
//   - No counter; FETCH/DROP wait indefinitely.
//   - fetch_err tied 0. The port remains present.
// TESTING
//  1 Reset: clr=1 mid-FETCH -> same cycle mem_read=0, instr_valid=0, instr=32'h13; release -> IDLE latches pc_val.
//  2 Basic: pc_val=0x100, ack 1st cycle with rdata=0x00500093, ready=1 -> cycle n+2 instr=0x00500093, instr_pc=0x100; pc_stall=0 only that cycle.
//  3 Backpressure: instr_ready=0 for 5 cycles -> instr_valid, instr, instr_pc stable, pc_stall=1, mem_read=0 throughout.
//  4 Flush: flush in FETCH with ack delayed 3 cycles -> DROP holds mem_read and addr; ack data discarded; no instr_valid; next fetch uses new pc_val=0x200.
//  5 Misaligned/wait: pc_val=0x102, ack after 4 cycles -> mem_addr=0x100 held 4 cycles; instr_pc=0x102.
//  6 Timeout (IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack -> after 4 cycles instr_valid=1, instr=32'h13, fetch_err=1; clears after handshake.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage sitting directly after the program counter register.
//
// Reads one word at the current PC from instruction memory over a req/ack handshake.
// It then presents that word to decode over a valid/ready handshake.
// The PC is held through pc_stall until decode accepts the word.
// A flush (taken branch or jump) discards the fetch that is in flight.
//
// Optional feature (macro IFETCH_TIMEOUT_EN):
//   A fetch that gets no mem_ack for TIMEOUT_CYCLES cycles is aborted.
//   Decode then receives RESET_INSTR with fetch_err set.
//   Without the macro, fetches wait indefinitely and fetch_err is always 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   clr          in   asynchronous active-high reset
//   pc_val       in   current PC
//   flush        in   discard current fetch / instruction
//   instr_ready  in   decode accepts instr this cycle
//   instr        out  fetched instruction
//   instr_pc     out  address instr was fetched from
//   instr_valid  out  instr / instr_pc valid
//   pc_stall     out  hold PC; low only on the accept cycle
//   mem_read     out  memory read request, held until mem_ack
//   mem_addr     out  word-aligned read address
//   mem_rdata    in   read data, sampled when mem_ack = 1
//   mem_ack      in   read complete
//   fetch_err    out  instr is a timeout substitute
module instr_fetch #(
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc_val,
  input  logic        flush,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        pc_stall,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        fetch_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        err_q, err_d;
  logic        timeout;

`ifdef IFETCH_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The timeout fires in the cycle in which the count would reach TIMEOUT_CYCLES.
  assign timeout = ~mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    unique case (state_q)
      StIdle:  cnt_d = '0;  // the next state is always FETCH
      StFetch: begin
        if (!mem_ack && flush) begin
          cnt_d = '0;         // entry to DROP
        end else if (!mem_ack) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrop:  if (!mem_ack) cnt_d = cnt_q + 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) || (CNT_W == 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        // A stray mem_ack here belongs to nothing and is ignored.
        addr_d  = pc_val;
        state_d = StFetch;
      end
      StFetch: begin
        if (mem_ack) begin
          if (flush) begin
            state_d = StIdle;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = addr_q;
            err_d      = 1'b0;
            state_d    = StValid;
          end
        end else if (flush) begin
          state_d = StDrop;
        end else if (timeout) begin
          instr_d    = RESET_INSTR;
          instr_pc_d = addr_q;
          err_d      = 1'b1;
          state_d    = StValid;
        end
      end
      StDrop: begin
        // Wait for the abandoned read to complete so its ack cannot be mistaken for a new one.
        if (mem_ack || timeout) state_d = StIdle;
      end
      StValid: begin
        if (flush || instr_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      instr_q    <= RESET_INSTR;
      instr_pc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      err_q      <= err_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == StValid);
  assign mem_read    = (state_q == StFetch) || (state_q == StDrop);
  // addr_q only changes on leaving IDLE, so the address holds outside FETCH/DROP.
  assign mem_addr    = {addr_q[31:2], 2'b00};
  assign pc_stall    = ~((state_q == StValid) && instr_ready && !flush);
  assign fetch_err   = err_q;

endmodule
